// File: rtl/arbiter_types.sv
// -----------------------------------------------------------------------------
// arbiter_types
// Shared types for the cache arbiter: the arbiter state encoding, the
// requester identity, and the tie-break helper that picks which cache owns
// the next physical-memory transaction.
// -----------------------------------------------------------------------------
package arbiter_types;

    // Arbiter states. RELEASE is a one-cycle bubble after every completed
    // transaction so the finished requester can drop its request line before
    // IDLE samples the requests again.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // Requester identity, also used as the last-grant record.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_e;

    // Choose the winner among the active requesters. A lone requester always
    // wins; on a tie the requester that did NOT win last time gets the grant.
    // The result is only meaningful when at least one request is active.
    function automatic requester_e pick_winner(
        input logic       i_req,
        input logic       d_req,
        input requester_e last_grant
    );
        requester_e winner;
        if (d_req && (!i_req || (last_grant == REQ_I))) begin
            winner = REQ_D;
        end else begin
            winner = REQ_I;
        end
        return winner;
    endfunction

endpackage : arbiter_types

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Shares one physical-memory port between an I-cache (line fills only) and a
// D-cache (line fills and write-backs). One transaction is in flight at a
// time. The winning request's address, operation and write data are latched
// when the grant is taken, so the memory command is stable for the whole
// transaction no matter what either cache does with its inputs meanwhile.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   i_read, i_addr     I-cache line-fill request and line address
//   i_rdata, i_resp    line returned to the I-cache, completion pulse
//   d_read, d_write    D-cache fill / write-back request (both high = write)
//   d_addr, d_wdata    D-cache line address and write-back line
//   d_rdata, d_resp    line returned to the D-cache, completion pulse
//   pmem_read/_write   physical memory command (registered)
//   pmem_addr/_wdata   physical memory address / write line (registered)
//   pmem_rdata/_resp   physical memory read line and completion
// -----------------------------------------------------------------------------
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // ---------------------------------------------------------------------
    // State and latched-transaction registers
    // ---------------------------------------------------------------------
    arb_state_e        r_state;
    requester_e        r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_pmem_read;
    logic              r_pmem_write;

    // ---------------------------------------------------------------------
    // Combinational decisions
    // ---------------------------------------------------------------------
    arb_state_e        w_next_state;
    logic              w_grant;
    requester_e        w_winner;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_win_write;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // A D-cache grant is a write-back whenever d_write is high, even if
    // d_read is also high; I-cache grants are always reads.
    assign w_win_write = (w_winner == REQ_D) & d_write;

    // Next-state logic and grant decision.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_winner     = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_grant      = 1'b1;
                    w_winner     = pick_winner(w_i_req, w_d_req, r_last_grant);
                    w_next_state = (w_winner == REQ_D) ? GRANT_D : GRANT_I;
                end else begin
                    w_next_state = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    w_next_state = RELEASE;
                end else begin
                    w_next_state = r_state;
                end
            end
            RELEASE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Completion pulses: only the current owner sees pmem_resp, and a reset
    // in the same cycle abandons the transaction without reporting it.
    always_comb begin
        i_resp = 1'b0;
        d_resp = 1'b0;
        if (pmem_resp && !rst) begin
            case (r_state)
                GRANT_I: i_resp = 1'b1;
                GRANT_D: d_resp = 1'b1;
                default: begin
                    i_resp = 1'b0;
                    d_resp = 1'b0;
                end
            endcase
        end else begin
            i_resp = 1'b0;
            d_resp = 1'b0;
        end
    end

    // State register plus the transaction latch. The command bits are set
    // when a grant is taken and cleared as soon as the FSM leaves the grant
    // states, so RELEASE and IDLE never drive a memory command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_I;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {LINE_W{1'b0}};
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_last_grant <= w_winner;
                r_addr       <= (w_winner == REQ_D) ? d_addr : i_addr;
                r_wdata      <= d_wdata;
                r_pmem_read  <= ~w_win_write;
                r_pmem_write <= w_win_write;
            end else if ((w_next_state != GRANT_I) && (w_next_state != GRANT_D)) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
            end else begin
                r_pmem_read  <= r_pmem_read;
                r_pmem_write <= r_pmem_write;
            end
        end
    end

    // Memory-side outputs come straight from the latch registers.
    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_addr  = r_addr;
    assign pmem_wdata = r_wdata;

    // Read data is broadcast to both caches; the resp pulse marks the owner.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
// Directed stimulus for cache_arbiter with a transaction-level reference
// model checked every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a transaction is either absent, in progress for an
    // owner (0 = I, 1 = D), or in its post-completion bubble.
    // ---------------------------------------------------------------------
    localparam int PH_FREE   = 0;
    localparam int PH_BUSY   = 1;
    localparam int PH_BUBBLE = 2;

    bit                m_en    = 1'b0;
    int                m_phase = PH_FREE;
    int                m_owner = 0;
    int                m_last  = 0;
    bit                m_write = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    int                log_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (m_en) begin
                logic busy;
                logic ir_req;
                logic dr_req;
                busy = (m_phase == PH_BUSY);
                check("m_pmem_read",  pmem_read,  busy && !m_write);
                check("m_pmem_write", pmem_write, busy && m_write);
                check("m_pmem_addr",  pmem_addr,  m_addr);
                check("m_pmem_wdata", pmem_wdata, m_wdata);
                check("m_i_resp", i_resp, busy && (m_owner == 0) && pmem_resp && !rst);
                check("m_d_resp", d_resp, busy && (m_owner == 1) && pmem_resp && !rst);
                check("m_resp_excl", i_resp & d_resp, 1'b0);
                check("m_i_rdata", i_rdata, pmem_rdata);
                check("m_d_rdata", d_rdata, pmem_rdata);
                if (i_resp === 1'b1) log_q.push_back(0);
                if (d_resp === 1'b1) log_q.push_back(1);

                // Advance the model with the inputs the DUT samples next edge.
                ir_req = i_read;
                dr_req = d_read | d_write;
                if (rst) begin
                    m_phase = PH_FREE;
                    m_last  = 0;
                    m_write = 1'b0;
                    m_addr  = '0;
                    m_wdata = '0;
                end else if (m_phase == PH_FREE) begin
                    if (ir_req || dr_req) begin
                        if (ir_req && dr_req) m_owner = 1 - m_last;
                        else if (dr_req)      m_owner = 1;
                        else                  m_owner = 0;
                        m_last  = m_owner;
                        m_phase = PH_BUSY;
                        m_addr  = (m_owner == 1) ? d_addr : i_addr;
                        m_write = (m_owner == 1) && d_write;
                        m_wdata = d_wdata;
                    end
                end else if (m_phase == PH_BUSY) begin
                    if (pmem_resp) m_phase = PH_BUBBLE;
                end else begin
                    m_phase = PH_FREE;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for a memory command, then answer after dly cycles.
    task automatic serve(input int dly, input logic [LINE_W-1:0] data);
        int t;
        t = 0;
        while (!(pmem_read || pmem_write) && (t < 20)) begin
            step(1);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL serve_timeout actual=no_command required=command");
        end else begin
            step(dly);
            pmem_rdata = data;
            pmem_resp  = 1'b1;
            step(1);
            pmem_resp  = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_read     = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        // Reset state
        step(1);
        m_en = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_pmem_read",  pmem_read,  1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_addr",  pmem_addr,  32'h0000_0000);
        check("rst_i_resp",     i_resp,     1'b0);
        check("rst_d_resp",     d_resp,     1'b0);

        // Lone I read: command one cycle later, answered five cycles later
        i_read = 1'b1;
        i_addr = 32'h0000_1000;
        step(1);
        check("A_cmd_latency", pmem_read, 1'b1);
        check("A_pmem_addr",   pmem_addr, 32'h0000_1000);
        step(4);
        pmem_rdata = {8{32'hAAAA_AAAA}};
        pmem_resp  = 1'b1;
        #1;
        check("A_i_resp",  i_resp,  1'b1);
        check("A_d_resp",  d_resp,  1'b0);
        check("A_i_rdata", i_rdata, {8{32'hAAAA_AAAA}});
        step(1);
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        #1;
        check("A_release_cmd",  pmem_read, 1'b0);
        check("A_release_resp", i_resp,    1'b0);
        step(2);

        // Tie after reset, then alternation over four transactions
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        log_q.delete();
        i_read = 1'b1;
        d_read = 1'b1;
        i_addr = 32'h0000_2000;
        d_addr = 32'h0000_3000;
        serve(2, {8{32'h1234_5678}});
        serve(0, {8{32'h9ABC_DEF0}});
        serve(3, {8{32'h0BAD_F00D}});
        serve(1, {8{32'hCAFE_BABE}});
        i_read = 1'b0;
        d_read = 1'b0;
        step(2);
        check("B_resp_count", log_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            int got;
            got = (k < log_q.size()) ? log_q[k] : -1;
            check($sformatf("B_order_%0d", k), got, (k % 2 == 0) ? 1 : 0);
        end

        // D write-back (read+write both high acts as write), address frozen
        d_write = 1'b1;
        d_read  = 1'b1;
        d_addr  = 32'h8000_0040;
        d_wdata = {8{32'h5555_5555}};
        step(1);
        check("C_pmem_write", pmem_write, 1'b1);
        check("C_pmem_read",  pmem_read,  1'b0);
        check("C_pmem_addr",  pmem_addr,  32'h8000_0040);
        check("C_pmem_wdata", pmem_wdata, {8{32'h5555_5555}});
        d_addr = 32'hDEAD_0000;
        i_read = 1'b1;
        i_addr = 32'h0000_4000;
        step(2);
        check("C_addr_frozen", pmem_addr, 32'h8000_0040);
        pmem_rdata = {8{32'h0F0F_0F0F}};
        pmem_resp  = 1'b1;
        #1;
        check("C_d_resp", d_resp, 1'b1);
        check("C_i_resp", i_resp, 1'b0);
        step(1);
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        d_read    = 1'b0;
        serve(1, {8{32'h3333_CCCC}});
        i_read = 1'b0;
        step(2);

        // Reset during a D grant abandons it
        d_read = 1'b1;
        d_addr = 32'h0000_5000;
        step(1);
        check("D_granted", pmem_read, 1'b1);
        rst    = 1'b1;
        d_read = 1'b0;
        step(1);
        rst = 1'b0;
        check("D_rst_read",  pmem_read,  1'b0);
        check("D_rst_write", pmem_write, 1'b0);
        check("D_rst_resp",  d_resp,     1'b0);
        step(3);

        // Spurious pmem_resp while idle
        pmem_rdata = {8{32'h7777_7777}};
        pmem_resp  = 1'b1;
        #1;
        check("E_spur_i_resp", i_resp, 1'b0);
        check("E_spur_d_resp", d_resp, 1'b0);
        step(1);
        pmem_resp = 1'b0;
        check("E_spur_cmd", pmem_read | pmem_write, 1'b0);

        // Requester drops mid-grant; transaction still completes
        i_read = 1'b1;
        i_addr = 32'h0000_6000;
        step(1);
        i_read = 1'b0;
        check("F_cmd", pmem_read, 1'b1);
        step(3);
        check("F_held", pmem_read, 1'b1);
        pmem_rdata = {8{32'h4242_4242}};
        pmem_resp  = 1'b1;
        #1;
        check("F_i_resp", i_resp, 1'b1);
        step(1);
        pmem_resp = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cache_arbiter
